// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
// Widths match the 32-entry MIPS register file.
// Register 0 is hard-wired to zero, so writes to it are suppressed.
package regfile_pkg;

  localparam int REG_COUNT = 32;
  localparam int AW        = 5;
  localparam int DW        = 32;

  localparam logic [AW-1:0] ZERO_REG = 5'd0;

  // One buffered write-back: destination register plus result.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Purpose: small circular buffer for mult/div write-back entries.
// Latency: an entry pushed at edge E is visible at the head after E.
// Backpressure: a push while full and a pop while empty are ignored; the caller gates both with full/empty.
module wb_result_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  wb_entry_t       push_entry,
  input  logic            pop,
  output wb_entry_t       head,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Purpose: owns the register-file write port; merges ALU results (priority) with buffered mult/div results and tracks pending long-latency writes.
// Latency: ALU 1 edge; mult/div 2 edges through the FIFO, or 1 edge when built with WB_BYPASS_EN and the FIFO is empty.
// Backpressure: ALU is never stalled; mult/div uses md_valid/md_ready, where ready = FIFO not full (current state only).
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = regfile_pkg::AW,
  parameter  int DW    = regfile_pkg::DW,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [AW-1:0]        alu_addr,
  input  logic [DW-1:0]        alu_data,
  input  logic                 md_valid,
  output logic                 md_ready,
  input  logic [AW-1:0]        md_addr,
  input  logic [DW-1:0]        md_data,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_addr,
  output logic [REG_COUNT-1:0] pending_mask,
  output logic [CW-1:0]        fifo_count,
  output logic                 write_en,
  output logic [AW-1:0]        write_addr,
  output logic [DW-1:0]        write_data
);

  wb_entry_t            head;
  wb_entry_t            md_entry;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 md_accept;
  logic                 bypass;
  logic                 push;
  logic                 pop;
  logic                 sel_load;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_data;
  logic [REG_COUNT-1:0] set_mask;
  logic [REG_COUNT-1:0] clr_mask;

  // Ready is held low during reset so nothing is accepted into a clearing FIFO.
  assign md_ready  = reset & ~fifo_full;
  assign md_accept = md_valid & md_ready;
  assign md_entry  = '{addr: md_addr, data: md_data};

`ifdef WB_BYPASS_EN
  // An idle port with an empty FIFO lets a fresh result skip the buffer.
  assign bypass = md_accept & fifo_empty & ~alu_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = md_accept & ~bypass;
  assign pop  = ~alu_valid & ~fifo_empty;

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (md_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Pick this edge's write source: ALU first, then FIFO head, then bypass.
  always_comb begin
    sel_load = 1'b0;
    sel_addr = alu_addr;
    sel_data = alu_data;
    if (alu_valid) begin
      sel_load = 1'b1;
    end else if (pop) begin
      sel_load = 1'b1;
      sel_addr = head.addr;
      sel_data = head.data;
    end else if (bypass) begin
      sel_load = 1'b1;
      sel_addr = md_addr;
      sel_data = md_data;
    end
  end

  // Registered write port; address/data hold when idle, register 0 never enables.
  always_ff @(posedge clock) begin
    if (!reset) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else if (sel_load) begin
      write_en   <= (sel_addr != ZERO_REG);
      write_addr <= sel_addr;
      write_data <= sel_data;
    end else begin
      write_en   <= 1'b0;
    end
  end

  // Scoreboard set/clear requests; only mult/div writes clear bits.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (pop) begin
      clr_mask[head.addr] = 1'b1;
    end else if (bypass) begin
      clr_mask[md_addr] = 1'b1;
    end
    if (issue_valid && (issue_addr != ZERO_REG)) begin
      set_mask[issue_addr] = 1'b1;
    end
  end

  // Pending-write scoreboard; a same-edge set overrides the clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pending_mask <= '0;
    end else begin
      pending_mask <= (pending_mask & ~clr_mask) | set_mask;
    end
  end

endmodule
